// File: rtl/ex_muldiv_if.sv
// EX-stage mul/div request/response bundle.
// The requester drives op/operands/flush; the unit returns stall/done/HI/LO.
interface ex_muldiv_if #(
  parameter int DATA_W = 32
);
  logic              start_i;
  logic [2:0]        op_i;
  logic [DATA_W-1:0] reg1_i;
  logic [DATA_W-1:0] reg2_i;
  logic              flush_i;
  logic              stall_o;
  logic              done_o;
  logic [DATA_W-1:0] hi_o;
  logic [DATA_W-1:0] lo_o;

  modport master (
    output start_i, op_i, reg1_i, reg2_i, flush_i,
    input  stall_o, done_o, hi_o, lo_o
  );

  modport slave (
    input  start_i, op_i, reg1_i, reg2_i, flush_i,
    output stall_o, done_o, hi_o, lo_o
  );
endinterface

// File: rtl/ex_muldiv.sv
// EX-stage multiply/divide unit with HI/LO registers.
// Multi-cycle multiply, radix-2 restoring divide, pipeline stall/flush.
module ex_muldiv #(
  parameter int DATA_W  = 32,
  parameter int MUL_LAT = 3
) (
  input  logic        clk_i,
  input  logic        rst_i,
  ex_muldiv_if.slave  bus
);

  localparam int CMAX = (DATA_W > MUL_LAT) ? DATA_W : MUL_LAT;
  localparam int CW   = $clog2(CMAX) + 1;
  localparam logic [CW-1:0] MUL_INIT = CW'(MUL_LAT - 1);
  localparam logic [CW-1:0] DIV_INIT = CW'(DATA_W - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_MUL,
    S_DIV,
    S_DONE
  } state_t;

  state_t r_state;
  state_t w_next;

  logic [DATA_W-1:0]   r_hi;
  logic [DATA_W-1:0]   r_lo;
  logic [DATA_W-1:0]   r_a;
  logic [DATA_W-1:0]   r_b;
  logic [DATA_W-1:0]   r_rem;
  logic [CW-1:0]       r_cnt;
  logic                r_msgn;
  logic                r_qneg;
  logic                r_rneg;
  logic                r_dz;
  logic                r_fin;

  logic                w_go;
  logic                w_mul;
  logic                w_div;
  logic                w_mthi;
  logic                w_mtlo;
  logic                w_sdiv;
  logic                w_stall;
  logic                w_done;
  logic [DATA_W-1:0]   w_absa;
  logic [DATA_W-1:0]   w_absb;
  logic [2*DATA_W-1:0] w_ax;
  logic [2*DATA_W-1:0] w_bx;
  logic [2*DATA_W-1:0] w_prod;
  logic [DATA_W:0]     w_sh;
  logic [DATA_W:0]     w_diff;
  logic [DATA_W-1:0]   w_q_nx;
  logic [DATA_W-1:0]   w_rem_nx;

  assign w_go   = (r_state == S_IDLE) && bus.start_i && !bus.flush_i;
  assign w_mul  = (bus.op_i == 3'd1) || (bus.op_i == 3'd2);
  assign w_div  = (bus.op_i == 3'd3) || (bus.op_i == 3'd4);
  assign w_mthi = (bus.op_i == 3'd5);
  assign w_mtlo = (bus.op_i == 3'd6);
  assign w_sdiv = (bus.op_i == 3'd3);

  assign w_absa = (w_sdiv && bus.reg1_i[DATA_W-1]) ? -bus.reg1_i
                                                   : bus.reg1_i;
  assign w_absb = (w_sdiv && bus.reg2_i[DATA_W-1]) ? -bus.reg2_i
                                                   : bus.reg2_i;

  // Sign/zero extension to 2W makes one unsigned multiply serve both forms
  assign w_ax = r_msgn ? {{DATA_W{r_a[DATA_W-1]}}, r_a}
                       : {{DATA_W{1'b0}}, r_a};
  assign w_bx = r_msgn ? {{DATA_W{r_b[DATA_W-1]}}, r_b}
                       : {{DATA_W{1'b0}}, r_b};
  assign w_prod = w_ax * w_bx;

  // Restoring step: r_a shifts out dividend bits and shifts in quotient bits
  assign w_sh     = {r_rem, r_a[DATA_W-1]};
  assign w_diff   = w_sh - {1'b0, r_b};
  assign w_q_nx   = {r_a[DATA_W-2:0], ~w_diff[DATA_W]};
  assign w_rem_nx = w_diff[DATA_W] ? w_sh[DATA_W-1:0]
                                   : w_diff[DATA_W-1:0];

  always_ff @(posedge clk_i) begin
    if (rst_i) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next  = r_state;
    w_stall = 1'b0;
    w_done  = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (w_go && w_mul) begin
          w_next  = S_MUL;
          w_stall = 1'b1;
        end else if (w_go && w_div) begin
          w_next  = S_DIV;
          w_stall = 1'b1;
        end
      end
      S_MUL: begin
        w_stall = 1'b1;
        if (bus.flush_i)        w_next = S_IDLE;
        else if (r_cnt == '0)   w_next = S_DONE;
      end
      S_DIV: begin
        w_stall = 1'b1;
        if (bus.flush_i)        w_next = S_IDLE;
        else if (r_fin)         w_next = S_DONE;
      end
      S_DONE: begin
        w_done = 1'b1;
        w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_hi   <= '0;
      r_lo   <= '0;
      r_a    <= '0;
      r_b    <= '0;
      r_rem  <= '0;
      r_cnt  <= '0;
      r_msgn <= 1'b0;
      r_qneg <= 1'b0;
      r_rneg <= 1'b0;
      r_dz   <= 1'b0;
      r_fin  <= 1'b0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (w_go) begin
            unique case (1'b1)
              w_mul: begin
                r_a    <= bus.reg1_i;
                r_b    <= bus.reg2_i;
                r_msgn <= (bus.op_i == 3'd1);
                r_cnt  <= MUL_INIT;
              end
              w_div: begin
                r_a    <= w_absa;
                r_b    <= w_absb;
                r_rem  <= '0;
                r_qneg <= w_sdiv &&
                          (bus.reg1_i[DATA_W-1] ^ bus.reg2_i[DATA_W-1]);
                r_rneg <= w_sdiv && bus.reg1_i[DATA_W-1];
                r_dz   <= (bus.reg2_i == '0);
                r_fin  <= 1'b0;
                r_cnt  <= DIV_INIT;
              end
              w_mthi: r_hi <= bus.reg1_i;
              w_mtlo: r_lo <= bus.reg1_i;
              default: ;
            endcase
          end
        end
        S_MUL: begin
          if (!bus.flush_i) begin
            if (r_cnt == '0) {r_hi, r_lo} <= w_prod;
            else             r_cnt <= r_cnt - 1'b1;
          end
        end
        S_DIV: begin
          if (!bus.flush_i) begin
            if (r_fin) begin
              // Divide by zero leaves an all-ones quotient regardless of sign
              r_lo <= r_dz ? '1 : (r_qneg ? -r_a : r_a);
              r_hi <= r_rneg ? -r_rem : r_rem;
            end else begin
              r_a   <= w_q_nx;
              r_rem <= w_rem_nx;
              if (r_cnt == '0) r_fin <= 1'b1;
              else             r_cnt <= r_cnt - 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.stall_o = w_stall;
  assign bus.done_o  = w_done;
  assign bus.hi_o    = r_hi;
  assign bus.lo_o    = r_lo;

endmodule
